// File: rtl/mpwb_ram_pkg.sv
// Shared types and constants for the multi-port banked Wishbone RAM.
package mpwb_ram_pkg;

    localparam int unsigned SEL_W  = 4;
    localparam int unsigned DATA_W = 32;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } port_state_e;

    // Write payload routed from the granted port onto a bank
    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] data;
    } wr_payload_t;

endpackage

// File: rtl/mpwb_bank_arbiter.sv
// Per-bank arbiter: fixed lowest-index priority or round robin after the last grant.
module mpwb_bank_arbiter
    import mpwb_ram_pkg::*;
#(
    parameter int unsigned  NUM_PORTS = 2,
    localparam int unsigned PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  arb_mode_e            mode,
    input  logic [NUM_PORTS-1:0] req,
    output logic [NUM_PORTS-1:0] grant,
    output logic [PTR_W-1:0]     ptr
);

    logic [PTR_W-1:0] ptr_next;

    // Scan in reverse and overwrite so the highest-priority requester ends up granted
    always_comb begin
        int unsigned idx;
        grant    = '0;
        ptr_next = ptr;
        idx      = 0;
        if (mode == ARB_FIXED) begin
            for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
                if (req[i]) begin
                    grant    = '0;
                    grant[i] = 1'b1;
                    ptr_next = PTR_W'(i);
                end
            end
        end else begin
            for (int unsigned k = NUM_PORTS; k >= 1; k--) begin
                idx = (32'(ptr) + k) % NUM_PORTS;
                if (req[idx]) begin
                    grant      = '0;
                    grant[idx] = 1'b1;
                    ptr_next   = PTR_W'(idx);
                end
            end
        end
    end

    // Last-grant pointer; reset to the top port so port 0 wins first
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr <= PTR_W'(NUM_PORTS - 1);
        end else if (|grant) begin
            ptr <= ptr_next;
        end
    end

endmodule

// File: rtl/multi_port_wb_ram.sv
// N-port, M-bank Wishbone scratch RAM; ports hitting different banks proceed in parallel.
module multi_port_wb_ram
    import mpwb_ram_pkg::*;
#(
    parameter int unsigned  NUM_PORTS      = 2,
    parameter int unsigned  NUM_BANKS      = 2,
    parameter int unsigned  WORDS_PER_BANK = 256,
    parameter arb_mode_e    ARB_MODE       = ARB_RR,
    localparam int unsigned BANK_BITS      = $clog2(NUM_BANKS),
    localparam int unsigned WORD_BITS      = $clog2(WORDS_PER_BANK),
    localparam int unsigned ADDR_W         = 2 + WORD_BITS + BANK_BITS
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_PORTS-1:0]          wb_cyc_i,
    input  logic [NUM_PORTS-1:0]          wb_stb_i,
    input  logic [NUM_PORTS*SEL_W-1:0]    wb_we_i,
    input  logic [NUM_PORTS*ADDR_W-1:0]   wb_addr_i,
    input  logic [NUM_PORTS*DATA_W-1:0]   wb_data_i,
    output logic [NUM_PORTS*DATA_W-1:0]   wb_data_o,
    output logic [NUM_PORTS-1:0]          wb_ack_o,
    output logic [NUM_PORTS-1:0]          wb_stall_o
);

    localparam int unsigned BANK_W = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int unsigned PTR_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    port_state_e                          state      [NUM_PORTS];
    port_state_e                          state_next [NUM_PORTS];
    logic [NUM_PORTS-1:0]                 req;
    logic [NUM_PORTS-1:0]                 gnt;
    logic [BANK_W-1:0]                    bank_of    [NUM_PORTS];
    logic [WORD_BITS-1:0]                 word_of    [NUM_PORTS];
    logic [NUM_BANKS-1:0][NUM_PORTS-1:0]  bank_req;
    logic [NUM_BANKS-1:0][NUM_PORTS-1:0]  bank_gnt;
    logic [PTR_W-1:0]                     bank_ptr   [NUM_BANKS];
    logic [DATA_W-1:0]                    bank_rdata [NUM_BANKS];
    logic                                 unused_bits;

    // Address decode; a port only requests while its FSM is idle
    always_comb begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            bank_of[p] = BANK_W'(wb_addr_i[p*ADDR_W +: ADDR_W] >> (2 + WORD_BITS));
            word_of[p] = wb_addr_i[p*ADDR_W + 2 +: WORD_BITS];
            req[p]     = wb_cyc_i[p] & wb_stb_i[p] & (state[p] == IDLE);
        end
    end

    always_comb begin
        bank_req = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                bank_req[b][p] = req[p] & (32'(bank_of[p]) == b);
            end
        end
    end

    always_comb begin
        gnt = '0;
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            gnt = gnt | bank_gnt[b];
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_W-1:0]    mem [WORDS_PER_BANK];
        logic [WORD_BITS-1:0] word;
        wr_payload_t          wr;

        mpwb_bank_arbiter #(
            .NUM_PORTS (NUM_PORTS)
        ) u_arb (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .mode  (ARB_MODE),
            .req   (bank_req[b]),
            .grant (bank_gnt[b]),
            .ptr   (bank_ptr[b])
        );

        // Route the (single) granted port onto this bank
        always_comb begin
            word = '0;
            wr   = '0;
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                if (bank_gnt[b][p]) begin
                    word    = word_of[p];
                    wr.sel  = wb_we_i[p*SEL_W +: SEL_W];
                    wr.data = wb_data_i[p*DATA_W +: DATA_W];
                end
            end
        end

        assign bank_rdata[b] = mem[word];

        // Storage is deliberately not reset; reads carry a zero mask so never write
        always_ff @(posedge clk_i) begin
            for (int unsigned i = 0; i < SEL_W; i++) begin
                if (wr.sel[i]) begin
                    mem[word][8*i +: 8] <= wr.data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            state_next[p] = state[p];
            case (state[p])
                IDLE:    if (gnt[p]) state_next[p] = ACK;
                ACK:     state_next[p] = IDLE;
                default: state_next[p] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                state[p] <= IDLE;
            end
            wb_ack_o  <= '0;
            wb_data_o <= '0;
        end else begin
            for (int unsigned p = 0; p < NUM_PORTS; p++) begin
                state[p]    <= state_next[p];
                wb_ack_o[p] <= (state_next[p] == ACK);
                if (gnt[p]) begin
                    wb_data_o[p*DATA_W +: DATA_W] <= (wb_we_i[p*SEL_W +: SEL_W] != '0)
                                                     ? '0 : bank_rdata[bank_of[p]];
                end
            end
        end
    end

    // Stall is combinational so a master sees it in its request cycle
    always_comb begin
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            wb_stall_o[p] = (wb_cyc_i[p] & wb_stb_i[p] & ~gnt[p]) | (state[p] == ACK);
        end
    end

    always_comb begin
        unused_bits = 1'b0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            unused_bits = unused_bits ^ (^wb_addr_i[p*ADDR_W +: 2]);
        end
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
            unused_bits = unused_bits ^ (^bank_ptr[b]);
        end
    end

endmodule

// File: tb/tb_multi_port_wb_ram.sv
// Bench: a round-robin and a fixed-priority instance, each checked against its own memory/arbitration model.
module tb_multi_port_wb_ram;
    import mpwb_ram_pkg::*;

    localparam int unsigned NP  = 3;
    localparam int unsigned NB  = 2;
    localparam int unsigned WPB = 256;
    localparam int unsigned AW  = 11;
    localparam int unsigned NI  = 2;

    logic clk_i = 1'b0;
    logic rst_i;

    logic [NP-1:0]    cyc   [NI];
    logic [NP-1:0]    stb   [NI];
    logic [NP*4-1:0]  we    [NI];
    logic [NP*AW-1:0] addr  [NI];
    logic [NP*32-1:0] wdat  [NI];
    logic [NP*32-1:0] rdat  [NI];
    logic [NP-1:0]    ack   [NI];
    logic [NP-1:0]    stall [NI];

    always #5 clk_i = ~clk_i;

    multi_port_wb_ram #(.NUM_PORTS(NP), .NUM_BANKS(NB), .WORDS_PER_BANK(WPB), .ARB_MODE(ARB_RR)) dut_rr (
        .clk_i(clk_i), .rst_i(rst_i), .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]),
        .wb_addr_i(addr[0]), .wb_data_i(wdat[0]), .wb_data_o(rdat[0]), .wb_ack_o(ack[0]),
        .wb_stall_o(stall[0]));

    multi_port_wb_ram #(.NUM_PORTS(NP), .NUM_BANKS(NB), .WORDS_PER_BANK(WPB), .ARB_MODE(ARB_FIXED)) dut_fx (
        .clk_i(clk_i), .rst_i(rst_i), .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]),
        .wb_addr_i(addr[1]), .wb_data_i(wdat[1]), .wb_data_o(rdat[1]), .wb_ack_o(ack[1]),
        .wb_stall_o(stall[1]));

    // Reference model state, one copy per instance
    arb_mode_e   m_mode     [NI];
    bit          m_busy     [NI][NP];
    int          m_ptr      [NI][NB];
    logic [NP-1:0] m_gnt    [NI];
    bit          m_exp_ack  [NI][NP];
    logic [31:0] m_exp_data [NI][NP];
    logic [31:0] m_mem      [NI][NB*WPB];
    bit          pend       [NI][NP];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int onehot_idx(input logic [NP-1:0] v);
        case (v)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return 7;
        endcase
    endfunction

    task automatic set_port(input int i, input int p, input bit c, input bit s,
                            input logic [3:0] m, input int a, input logic [31:0] d);
        cyc[i][p]           = c;
        stb[i][p]           = s;
        we[i][p*4 +: 4]     = m;
        addr[i][p*AW +: AW] = AW'(a);
        wdat[i][p*32 +: 32] = d;
    endtask

    task automatic drive(input int p, input bit c, input bit s, input logic [3:0] m,
                         input int a, input logic [31:0] d);
        for (int i = 0; i < NI; i++) set_port(i, p, c, s, m, a, d);
    endtask

    task automatic idle_all();
        for (int p = 0; p < NP; p++) drive(p, 1'b0, 1'b0, 4'h0, 0, 32'h0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            for (int p = 0; p < NP; p++) begin
                m_busy[i][p]     = 1'b0;
                m_exp_ack[i][p]  = 1'b0;
                m_exp_data[i][p] = 32'h0;
                pend[i][p]       = 1'b0;
            end
            for (int b = 0; b < NB; b++) m_ptr[i][b] = NP - 1;
        end
    endtask

    // Per bank: pick one port among those requesting it, by the instance's policy
    task automatic model_arb(input int i);
        m_gnt[i] = '0;
        for (int b = 0; b < NB; b++) begin
            int win;
            win = -1;
            for (int k = 1; k <= NP; k++) begin
                int p;
                p = (m_mode[i] == ARB_FIXED) ? k - 1 : (m_ptr[i][b] + k) % NP;
                if (win < 0 && cyc[i][p] && stb[i][p] && !m_busy[i][p] &&
                    int'(addr[i][p*AW + AW - 1]) == b)
                    win = p;
            end
            if (win >= 0) begin
                m_gnt[i][win] = 1'b1;
                m_ptr[i][b]   = win;
            end
        end
    endtask

    task automatic model_commit(input int i);
        for (int p = 0; p < NP; p++) begin
            if (m_gnt[i][p]) begin
                int          w;
                logic [3:0]  m;
                logic [31:0] d;
                w = int'(addr[i][p*AW + 2 +: 9]);
                m = we[i][p*4 +: 4];
                d = wdat[i][p*32 +: 32];
                if (m != 4'h0) begin
                    for (int k = 0; k < 4; k++)
                        if (m[k]) m_mem[i][w][8*k +: 8] = d[8*k +: 8];
                    m_exp_data[i][p] = 32'h0;
                end else begin
                    m_exp_data[i][p] = m_mem[i][w];
                end
                m_exp_ack[i][p] = 1'b1;
                m_busy[i][p]    = 1'b1;
            end else begin
                m_exp_ack[i][p] = 1'b0;
                m_busy[i][p]    = 1'b0;
            end
        end
    endtask

    // One clock: inputs already driven after a negedge
    task automatic tick();
        #1;
        for (int i = 0; i < NI; i++) model_arb(i);
        for (int i = 0; i < NI; i++)
            for (int p = 0; p < NP; p++)
                check($sformatf("stall i%0d p%0d", i, p), 32'(stall[i][p]),
                      32'((cyc[i][p] & stb[i][p] & ~m_gnt[i][p]) | m_busy[i][p]));
        for (int i = 0; i < NI; i++) model_commit(i);
        @(posedge clk_i);
        @(negedge clk_i);
        for (int i = 0; i < NI; i++)
            for (int p = 0; p < NP; p++) begin
                check($sformatf("ack i%0d p%0d", i, p), 32'(ack[i][p]), 32'(m_exp_ack[i][p]));
                check($sformatf("data i%0d p%0d", i, p), rdat[i][p*32 +: 32], m_exp_data[i][p]);
            end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int rr_ord [6];
        int fx_ord [6];
        rr_ord = '{0, 1, 2, 0, 1, 2};
        fx_ord = '{0, 1, 0, 1, 0, 1};
        m_mode[0] = ARB_RR;
        m_mode[1] = ARB_FIXED;
        rst_i = 1'b1;
        idle_all();
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        for (int i = 0; i < NI; i++)
            for (int p = 0; p < NP; p++) begin
                check($sformatf("rst ack i%0d p%0d", i, p), 32'(ack[i][p]), 32'h0);
                check($sformatf("rst data i%0d p%0d", i, p), rdat[i][p*32 +: 32], 32'h0);
                check($sformatf("rst stall i%0d p%0d", i, p), 32'(stall[i][p]), 32'h0);
            end
        rst_i = 1'b0;

        // Parallel writes to different banks
        drive(0, 1'b1, 1'b1, 4'hF, 32'h000, 32'hDEADBEEF);
        drive(1, 1'b1, 1'b1, 4'hF, 32'h400, 32'hCAFEBABE);
        tick();
        for (int i = 0; i < NI; i++) begin
            check($sformatf("par ack0 i%0d", i), 32'(ack[i][0]), 32'h1);
            check($sformatf("par ack1 i%0d", i), 32'(ack[i][1]), 32'h1);
        end
        idle_all();
        tick();
        drive(0, 1'b1, 1'b1, 4'h0, 32'h400, 32'h0);
        drive(1, 1'b1, 1'b1, 4'h0, 32'h000, 32'h0);
        tick();
        for (int i = 0; i < NI; i++) begin
            check($sformatf("par rd0 i%0d", i), rdat[i][31:0], 32'hCAFEBABE);
            check($sformatf("par rd1 i%0d", i), rdat[i][63:32], 32'hDEADBEEF);
        end
        idle_all();
        tick();

        // Byte-masked write
        drive(2, 1'b1, 1'b1, 4'hF, 32'h010, 32'h11111111);
        tick();
        idle_all();
        tick();
        drive(2, 1'b1, 1'b1, 4'b0101, 32'h010, 32'hAABBCCDD);
        tick();
        idle_all();
        tick();
        drive(2, 1'b1, 1'b1, 4'h0, 32'h012, 32'h0);
        tick();
        for (int i = 0; i < NI; i++)
            check($sformatf("mask rd i%0d", i), rdat[i][95:64], 32'h11BB11DD);
        idle_all();
        tick();

        // Master abandons the cycle during its ack
        drive(1, 1'b1, 1'b1, 4'hF, 32'h020, 32'h22222222);
        tick();
        drive(1, 1'b0, 1'b0, 4'h0, 0, 32'h0);
        #1;
        for (int i = 0; i < NI; i++)
            check($sformatf("abort ack hold i%0d", i), 32'(ack[i][1]), 32'h1);
        tick();
        for (int i = 0; i < NI; i++)
            check($sformatf("abort ack drop i%0d", i), 32'(ack[i][1]), 32'h0);
        drive(0, 1'b1, 1'b1, 4'h0, 32'h020, 32'h0);
        tick();
        for (int i = 0; i < NI; i++)
            check($sformatf("abort rd i%0d", i), rdat[i][31:0], 32'h22222222);
        idle_all();
        tick();

        // Reset during an ack cycle
        drive(0, 1'b1, 1'b1, 4'hF, 32'h030, 32'h12345678);
        tick();
        rst_i = 1'b1;
        idle_all();
        #1;
        for (int i = 0; i < NI; i++)
            for (int p = 0; p < NP; p++) begin
                check($sformatf("midrst ack i%0d p%0d", i, p), 32'(ack[i][p]), 32'h0);
                check($sformatf("midrst data i%0d p%0d", i, p), rdat[i][p*32 +: 32], 32'h0);
                check($sformatf("midrst stall i%0d p%0d", i, p), 32'(stall[i][p]), 32'h0);
            end
        model_reset();
        @(negedge clk_i);
        rst_i = 1'b0;

        // All ports contend for bank 0
        drive(0, 1'b1, 1'b1, 4'h0, 32'h030, 32'h0);
        drive(1, 1'b1, 1'b1, 4'h0, 32'h010, 32'h0);
        drive(2, 1'b1, 1'b1, 4'h0, 32'h000, 32'h0);
        for (int t = 0; t < 6; t++) begin
            tick();
            check($sformatf("rr order t%0d", t), 32'(onehot_idx(ack[0])), 32'(rr_ord[t]));
            check($sformatf("fx order t%0d", t), 32'(onehot_idx(ack[1])), 32'(fx_ord[t]));
            if (t == 0)
                for (int i = 0; i < NI; i++)
                    check($sformatf("retained i%0d", i), rdat[i][31:0], 32'h12345678);
        end
        drive(0, 1'b0, 1'b0, 4'h0, 0, 32'h0);
        drive(1, 1'b0, 1'b0, 4'h0, 0, 32'h0);
        tick();
        check("fx p2 granted", 32'(ack[1][2]), 32'h1);
        tick();
        idle_all();
        tick();

        // Fill a window of each bank so random reads have known contents
        for (int w = 0; w < 32; w++) begin
            drive(w % NP, 1'b1, 1'b1, 4'hF, (w / 16) * 1024 + (w % 16) * 4, $urandom);
            tick();
            idle_all();
            tick();
        end

        // Random traffic; a master holds its request until the model grants it
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NI; i++)
                for (int p = 0; p < NP; p++)
                    if (!pend[i][p]) begin
                        int r;
                        r = int'($urandom_range(0, 9));
                        if (r < 3) begin
                            set_port(i, p, r == 1, 1'b0, 4'h0, 0, 32'h0);
                        end else begin
                            set_port(i, p, 1'b1, 1'b1,
                                     ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0,
                                     int'($urandom_range(0, 1)) * 1024 +
                                     int'($urandom_range(0, 15)) * 4 + int'($urandom_range(0, 3)),
                                     $urandom);
                            pend[i][p] = 1'b1;
                        end
                    end
            tick();
            for (int i = 0; i < NI; i++)
                for (int p = 0; p < NP; p++)
                    if (m_gnt[i][p]) pend[i][p] = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/multi_port_wb_ram.md
# multi_port_wb_ram

Parametrised N-port, M-bank Wishbone RAM. It generalises the two-port, two-macro shared RAM to any number of ports and banks, with a selectable fixed-priority or round-robin arbiter per bank. Every port can reach every bank, and ports that hit different banks proceed in the same cycle. It sits on the SoC bus as shared scratch memory between CPU, DMA and peripheral masters.

## Interface
- NUM_PORTS, 2: Wishbone slave ports, ≥1.
- NUM_BANKS, 2: RAM banks, power of two.
- WORDS_PER_BANK, 256: 32-bit words per bank, power of two.
- ARB_MODE, ARB_RR: per-bank arbitration, ARB_FIXED or ARB_RR.
- Derived: SEL_W=4, BANK_BITS=clog2(NUM_BANKS), WORD_BITS=clog2(WORDS_PER_BANK), ADDR_W=2+WORD_BITS+BANK_BITS (11 at defaults).

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- wb_cyc_i  in  NUM_PORTS  cycle per port.
- wb_stb_i  in  NUM_PORTS  strobe per port.
- wb_we_i  in  NUM_PORTS×4  byte write mask; nonzero = write, 0000 = read.
- wb_addr_i  in  NUM_PORTS×ADDR_W  byte address.
- wb_data_i  in  NUM_PORTS×32  write data.
- wb_data_o  out  NUM_PORTS×32  read data.
- wb_ack_o  out  NUM_PORTS  one-cycle acknowledge.
- wb_stall_o  out  NUM_PORTS  request not accepted this cycle.

## Operation
- Address decode: bank = addr[ADDR_W-1 -: BANK_BITS], word = addr[2 +: WORD_BITS], and addr[1:0] are ignored. At defaults, 0x000–0x3FF is bank 0 and 0x400–0x7FF is bank 1.
- A port requests when cyc&stb and its FSM is IDLE. Per bank, a combinational arbiter picks one requester targeting that bank.
  - ARB_FIXED: the lowest port index wins.
  - ARB_RR: the first requester after the last-granted port, modulo NUM_PORTS, wins. The last-grant pointer resets to NUM_PORTS-1, so port 0 wins first.
  - The pointer updates only on a grant.
- Granted port: the access executes at the clock edge.
  - Write: only the bytes with a mask bit set are updated. data_o is loaded with 0.
  - Read: data_o is loaded with the stored word.
- Per-port FSM:
  - IDLE: a grant moves the port to ACK.
  - ACK: ack_o=1 for exactly one cycle and stb is ignored. The port then returns unconditionally to IDLE.
  - A port completes at most one access per 2 cycles. A master holding stb until the edge after ack is not double-serviced.
- stall_o = (cyc&stb & ~grant) | (state==ACK).
- Ports targeting different banks are all granted in the same cycle. Same-bank contenders are serialised by the arbiter.
- Dropping cyc while in ACK does not cancel the access. ack still pulses and data is valid.
- Reset clears FSMs, ack_o, data_o and arbiter pointers. Memory contents are not reset.
- Reset asserted mid-ACK kills ack immediately. A write accepted before reset is retained.

## Timing
- Reset values: ack_o=0, data_o=0, FSMs in IDLE, stall_o=0 while no request.
- Latency: request accepted at edge k gives ack_o high in cycle k..k+1, with data_o valid in the same cycle.
- stall_o is combinational from inputs and state, valid in the same cycle as the request.
- data_o holds its value until the port's next accepted access.
- Under persistent contention with ARB_RR, a requester waits at most NUM_PORTS-1 grant cycles.

## Structure
- Package mpwb_ram_pkg holds:
  - arb_mode_e (ARB_FIXED, ARB_RR);
  - port_state_e (IDLE, ACK);
  - the SEL_W=4 and DATA_W=32 constants.
- Sub-module mpwb_bank_arbiter, one instance per bank:
  - inputs: request vector and mode;
  - outputs: one-hot grant and pointer register.
- Top level holds the bank storage as a behavioural byte-enabled array per bank, plus the address decode, per-port FSMs and the data_o/ack_o registers.

## Test plan
- Reset: assert rst_i during port 0's ACK cycle → ack_o drops in the same timestep, stall_o=0, data_o=0.
- Parallel banks: port 0 writes 0x000=DEADBEEF and port 1 writes 0x400=CAFEBABE in the same cycle, mask 1111 → both stall_o=0 and both ack the next cycle; readbacks return the exact values.
- Byte mask: write 0x010=11111111, then 0x010=AABBCCDD with mask 0101 → read returns 11BB11DD.
- Round robin, NUM_PORTS=3, ARB_RR: all ports hold reads to bank 0 → grant order p0, p1, p2, p0…; each port's stall_o lasts ≤2 cycles and ack sequences match.
- Fixed priority, NUM_PORTS=3, ARB_FIXED: same stimulus → p0, p1 alternate and p2 stays stalled until p0/p1 drop stb, then is granted the next cycle.
- Abort: port 1 drops cyc in its ACK cycle → ack still high for exactly 1 cycle; a write to 0x020=22222222 is visible on a later read.
